// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: state encoding, funct3 codes,
// error causes and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD0   = 3'd1;
    localparam logic [2:0] ST_LOAD1   = 3'd2;
    localparam logic [2:0] ST_STORE   = 3'd3;
    localparam logic [2:0] ST_STORE_B = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] CAUSE_BAD_F3   = 2'b00;
    localparam logic [1:0] CAUSE_LD_MISAL = 2'b01;
    localparam logic [1:0] CAUSE_ST_MISAL = 2'b10;
    localparam logic [1:0] CAUSE_FAULT    = 2'b11;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Access size minus one; doubles as the alignment mask for the offset.
    function automatic logic [1:0] access_size_m1(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic funct3_valid(input logic we, input logic [2:0] funct3);
        if (we)
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Byte-lane extraction and sign/zero extension of load data taken from the
// little-endian pair {word1, word0} starting at byte offset 'offset'.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word0,
    input  logic [23:0] word1,   // only bytes 4..6 can ever be reached
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [55:0] pair;
    logic [31:0] lane [4];
    logic [31:0] shifted;

    assign pair = {word1, word0};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = pair[gi*8 +: 32];
        end
    endgenerate

    assign shifted = lane[offset];

    always_comb begin
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   data = shifted;
            F3_LBU:  data = {24'b0, shifted[7:0]};
            F3_LHU:  data = {16'b0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: range/alignment checks, split accesses, load alignment.
// Define LSU_MISALIGNED_EN to split misaligned accesses instead of rejecting them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = 32'h0000_0000,
    parameter int unsigned DMEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  rsp_cause,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_read_data
);

    logic [2:0]  state_reg, state_next;
    lsu_req_t    req_reg, req_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;
    logic [1:0]  cause_reg, cause_next;
`ifdef LSU_MISALIGNED_EN
    logic [31:0] word0_reg, word0_next;
    logic        ld_spans;
`endif

    // Decode of the request being presented in IDLE.
    logic [1:0]  in_size_m1;
    logic [32:0] in_rel;
    logic [32:0] in_end_rel;
    logic        in_f3_ok;
    logic        in_fault;
    logic        in_single_store;
`ifndef LSU_MISALIGNED_EN
    logic        in_misal;
`endif

    assign in_size_m1 = access_size_m1(req_funct3);
    assign in_f3_ok   = funct3_valid(req_we, req_funct3);
    // Borrow flags addr < base; exact 33-bit end offset also covers 32-bit wrap.
    assign in_rel     = {1'b0, req_addr} - {1'b0, DMEM_BASE};
    assign in_end_rel = {1'b0, in_rel[31:0]} + {31'b0, in_size_m1};
    assign in_fault   = in_rel[32] || (in_end_rel > (33'(DMEM_SIZE) - 33'd1));
    assign in_single_store = (req_funct3 == F3_SB) || (req_addr[1:0] == 2'b00);
`ifndef LSU_MISALIGNED_EN
    assign in_misal   = (req_addr[1:0] & in_size_m1) != 2'b00;
`endif

    logic [31:0] word_addr;
    logic [7:0]  store_byte;
    logic [31:0] align_word0;
    logic [23:0] align_word1;
    logic [31:0] align_data;

    assign word_addr  = {req_reg.addr[31:2], 2'b00};
    assign store_byte = req_reg.wdata[{byte_cnt_reg, 3'b000} +: 8];

`ifdef LSU_MISALIGNED_EN
    assign ld_spans    = ({1'b0, req_reg.addr[1:0]} + {1'b0, access_size_m1(req_reg.funct3)}) > 3'd3;
    assign align_word0 = (state_reg == ST_LOAD1) ? word0_reg : mem_read_data;
    assign align_word1 = (state_reg == ST_LOAD1) ? mem_read_data[23:0] : 24'b0;
`else
    assign align_word0 = mem_read_data;
    assign align_word1 = 24'b0;
`endif

    lsu_load_align u_align (
        .word0  (align_word0),
        .word1  (align_word1),
        .offset (req_reg.addr[1:0]),
        .funct3 (req_reg.funct3),
        .data   (align_data)
    );

    always_comb begin
        state_next     = state_reg;
        req_next       = req_reg;
        byte_cnt_next  = byte_cnt_reg;
        rdata_next     = rdata_reg;
        err_next       = err_reg;
        cause_next     = cause_reg;
`ifdef LSU_MISALIGNED_EN
        word0_next     = word0_reg;
`endif
        mem_addr       = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_funct3     = '0;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    req_next      = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                    byte_cnt_next = '0;
                    rdata_next    = '0;
                    err_next      = 1'b1;
                    state_next    = ST_RESP;
                    if (!in_f3_ok)
                        cause_next = CAUSE_BAD_F3;
                    else if (in_fault)
                        cause_next = CAUSE_FAULT;
`ifndef LSU_MISALIGNED_EN
                    else if (in_misal)
                        cause_next = req_we ? CAUSE_ST_MISAL : CAUSE_LD_MISAL;
`endif
                    else begin
                        err_next   = 1'b0;
                        cause_next = '0;
                        if (!req_we)
                            state_next = ST_LOAD0;
                        else if (in_single_store)
                            state_next = ST_STORE;
                        else
                            state_next = ST_STORE_B;
                    end
                end
            end
            ST_LOAD0: begin
                mem_read   = 1'b1;
                mem_funct3 = F3_LW;
                mem_addr   = word_addr;
`ifdef LSU_MISALIGNED_EN
                word0_next = mem_read_data;
                if (ld_spans) begin
                    state_next = ST_LOAD1;
                end else begin
                    rdata_next = align_data;
                    state_next = ST_RESP;
                end
`else
                rdata_next = align_data;
                state_next = ST_RESP;
`endif
            end
`ifdef LSU_MISALIGNED_EN
            ST_LOAD1: begin
                mem_read   = 1'b1;
                mem_funct3 = F3_LW;
                mem_addr   = word_addr + 32'd4;
                rdata_next = align_data;
                state_next = ST_RESP;
            end
`endif
            ST_STORE: begin
                mem_write      = 1'b1;
                mem_funct3     = req_reg.funct3;
                mem_addr       = req_reg.addr;
                mem_write_data = req_reg.wdata;
                state_next     = ST_RESP;
            end
            // One byte store per cycle; byte k of wdata goes to addr+k.
            ST_STORE_B: begin
                mem_write      = 1'b1;
                mem_funct3     = F3_SB;
                mem_addr       = req_reg.addr + {30'b0, byte_cnt_reg};
                mem_write_data = {24'b0, store_byte};
                if (byte_cnt_reg == access_size_m1(req_reg.funct3))
                    state_next = ST_RESP;
                else
                    byte_cnt_next = byte_cnt_reg + 2'd1;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            req_reg      <= '0;
            byte_cnt_reg <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            cause_reg    <= '0;
`ifdef LSU_MISALIGNED_EN
            word0_reg    <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            byte_cnt_reg <= byte_cnt_next;
            rdata_reg    <= rdata_next;
            err_reg      <= err_next;
            cause_reg    <= cause_next;
`ifdef LSU_MISALIGNED_EN
            word0_reg    <= word0_next;
`endif
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_rdata = rsp_valid ? rdata_reg : 32'b0;
    assign rsp_err   = rsp_valid && err_reg;
    assign rsp_cause = rsp_valid ? cause_reg : 2'b00;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, reset-mid-store
// sequence and random traffic against a byte-array reference model.
`timescale 1ns/1ps
module tb_load_store_unit;

`ifdef LSU_MISALIGNED_EN
    localparam bit MISAL = 1'b1;
`else
    localparam bit MISAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_cause;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_cause(rsp_cause),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_funct3(mem_funct3), .mem_read_data(mem_read_data)
    );

    // Data memory seen by the DUT, plus an independent reference image.
    logic [7:0] dmem    [0:4095];
    logic [7:0] ref_mem [0:4095];
    int shape_bad = 0;

    assign mem_read_data = {dmem[{mem_addr[11:2], 2'd3}], dmem[{mem_addr[11:2], 2'd2}],
                            dmem[{mem_addr[11:2], 2'd1}], dmem[{mem_addr[11:2], 2'd0}]};

    // The memory only handles word reads, byte stores and aligned SH/SW.
    always @(posedge clk) begin
        if (mem_read && (mem_addr[1:0] != 2'b00 || mem_addr > 32'hFFF ||
                         mem_funct3 != 3'b010 || mem_write))
            shape_bad <= shape_bad + 1;
        else if (mem_write) begin
            if (mem_addr > 32'hFFF)
                shape_bad <= shape_bad + 1;
            else case (mem_funct3)
                3'b000: dmem[mem_addr[11:0]] <= mem_write_data[7:0];
                3'b001: if (mem_addr[0]) shape_bad <= shape_bad + 1;
                        else begin
                            dmem[mem_addr[11:0]]         <= mem_write_data[7:0];
                            dmem[mem_addr[11:0] + 12'd1] <= mem_write_data[15:8];
                        end
                3'b010: if (mem_addr[1:0] != 2'b00) shape_bad <= shape_bad + 1;
                        else for (int k = 0; k < 4; k++)
                            dmem[mem_addr[11:0] + 12'(k)] <= mem_write_data[8*k +: 8];
                default: shape_bad <= shape_bad + 1;
            endcase
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [1:0]  cause;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;
    int n_txn  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h, required %08h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input logic [1:0] cause,
                                input logic [31:0] rdata, input int lat, input int nrd, input int nwr);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.err = err; v.cause = cause;
        v.rdata = rdata; v.lat = lat; v.nrd = nrd; v.nwr = nwr;
        return v;
    endfunction

    task automatic poke(input int a, input logic [7:0] b);
        dmem[a] <= b;
        ref_mem[a] = b;
    endtask

    // Reference behaviour from the access rules; applies successful stores to ref_mem.
    task automatic model(input vec_t v, output vec_t e);
        longint unsigned a;
        int size;
        bit f3_ok;
        logic [31:0] val;
        a = longint'(v.addr);
        size = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
        f3_ok = v.we ? (v.f3 <= 3'd2) : (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e = v;
        e.err = 1'b1; e.cause = 2'd0; e.rdata = '0; e.lat = 1; e.nrd = 0; e.nwr = 0;
        if (!f3_ok) e.cause = 2'd0;
        else if (a + longint'(size) - 1 > 4095) e.cause = 2'd3;
        else if ((a % longint'(size)) != 0 && !MISAL) e.cause = v.we ? 2'd2 : 2'd1;
        else if (!v.we) begin
            e.err = 1'b0;
            e.lat = ((a % 4) + longint'(size) > 4) ? 3 : 2;
            e.nrd = e.lat - 1;
            val = '0;
            for (int k = 0; k < size; k++) val[8*k +: 8] = ref_mem[int'(a) + k];
            if (v.f3 == 3'd0) val = {{24{val[7]}}, val[7:0]};
            if (v.f3 == 3'd1) val = {{16{val[15]}}, val[15:0]};
            e.rdata = val;
        end else begin
            e.err = 1'b0;
            if (size == 1 || (a % 4) == 0) begin e.lat = 2; e.nwr = 1; end
            else begin e.lat = 1 + size; e.nwr = size; end
            for (int k = 0; k < size; k++) ref_mem[int'(a) + k] = v.wdata[8*k +: 8];
        end
    endtask

    task automatic do_txn(input vec_t v, output vec_t g, output int rd_bad);
        bit done;
        g = v; g.err = 1'bx; g.cause = 'x; g.rdata = 'x; g.lat = -1; g.nrd = 0; g.nwr = 0;
        rd_bad = 0;
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        done = 0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (mem_read) begin
                if (mem_addr !== ({v.addr[31:2], 2'b00} + 32'(4 * g.nrd))) rd_bad++;
                g.nrd++;
            end
            if (mem_write) g.nwr++;
            if (rsp_valid) begin
                done = 1; g.lat = c; g.err = rsp_err; g.cause = rsp_cause; g.rdata = rsp_rdata;
            end
        end
        n_txn++;
        $display("txn %0d we=%0d f3=%0d addr=%08h wdata=%08h -> err=%0d cause=%0d rdata=%08h lat=%0d rd=%0d wr=%0d",
                 n_txn, v.we, v.f3, v.addr, v.wdata, g.err, g.cause, g.rdata, g.lat, g.nrd, g.nwr);
    endtask

    task automatic compare(input string tag, input vec_t g, input vec_t e, input int rd_bad);
        chk({tag, "_err"},   {31'b0, g.err},   {31'b0, e.err});
        chk({tag, "_cause"}, {30'b0, g.cause}, {30'b0, e.cause});
        chk({tag, "_rdata"}, g.rdata, e.rdata);
        chk({tag, "_lat"},   32'(g.lat), 32'(e.lat));
        chk({tag, "_reads"}, 32'(g.nrd), 32'(e.nrd));
        chk({tag, "_writes"}, 32'(g.nwr), 32'(e.nwr));
        if (g.nrd > 0) chk({tag, "_rdaddr"}, 32'(rd_bad), 32'd0);
    endtask

    task automatic reset_mid_store();
        vec_t v, g, e;
        int k, seen, rb;
        logic [31:0] a, wd;
`ifdef LSU_MISALIGNED_EN
        a = 32'h41; wd = 32'hA1B2C3D4; k = 3;
        v = mk(1'b1, 3'd2, a, wd, 0, 0, 0, 0, 0, 0);
`else
        a = 32'h46; wd = 32'h0000A1B2; k = 2;
        v = mk(1'b1, 3'd1, a, wd, 0, 0, 0, 0, 0, 0);
`endif
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= k; c++) @(negedge clk);
        chk("rst_mid_write_active", {31'b0, mem_write}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_mid_mem_write", {31'b0, mem_write}, 32'd0);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rst_mid_no_rsp", 32'(seen), 32'd0);
        for (int j = 0; j < k - 1; j++) begin
            chk("rst_mid_byte", {24'b0, dmem[int'(a) + j]}, {24'b0, wd[8*j +: 8]});
            ref_mem[int'(a) + j] = wd[8*j +: 8];
        end
        if (MISAL) chk("rst_mid_untouched", {24'b0, dmem[int'(a) + 3]}, 32'd0);
        // Byte k-1 was being written as reset hit; overwrite it with a known value.
        v = mk(1'b1, 3'd0, a + 32'(k - 1), 32'h5C, 0, 0, 0, 0, 0, 0);
        model(v, e);
        do_txn(v, g, rb);
        compare("rst_fixup", g, e, rb);
    endtask

    vec_t tbl[$];

    initial begin
        vec_t g, e, v;
        int rb, diffs, r;

        for (int i = 0; i < 4096; i++) begin dmem[i] <= 8'h00; ref_mem[i] = 8'h00; end
        poke('h10, 8'hEF); poke('h11, 8'hBE); poke('h12, 8'hAD); poke('h13, 8'hDE);
        poke('h20, 8'h88); poke('h21, 8'h77); poke('h22, 8'h66); poke('h23, 8'h55);
        poke('hFFF, 8'h9A);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_err",   {31'b0, rsp_err},   32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_mem_rw",    {30'b0, mem_read, mem_write}, 32'd0);
        chk("reset_mem_addr",  mem_addr, 32'd0);
        reset = 1'b0;

        //            we f3  addr            wdata          err cause rdata         lat rd wr
        tbl.push_back(mk(0, 2, 32'h10,       0,             0, 0, 32'hDEADBEEF, 2, 1, 0));
        tbl.push_back(mk(1, 2, 32'h10,       32'h80112233,  0, 0, 0,            2, 0, 1));
        tbl.push_back(mk(0, 0, 32'h13,       0,             0, 0, 32'hFFFFFF80, 2, 1, 0));
        tbl.push_back(mk(0, 4, 32'h13,       0,             0, 0, 32'h00000080, 2, 1, 0));
        tbl.push_back(mk(0, 1, 32'h12,       0,             0, 0, 32'hFFFF8011, 2, 1, 0));
        tbl.push_back(mk(1, 1, 32'h22,       32'hFFFFABCD,  0, 0, 0,            3, 0, 2));
        tbl.push_back(mk(0, 5, 32'h22,       0,             0, 0, 32'h0000ABCD, 2, 1, 0));
        tbl.push_back(mk(0, 2, 32'h20,       0,             0, 0, 32'hABCD7788, 2, 1, 0));
        tbl.push_back(mk(1, 1, 32'h24,       32'h00001234,  0, 0, 0,            2, 0, 1));
        tbl.push_back(mk(0, 2, 32'h24,       0,             0, 0, 32'h00001234, 2, 1, 0));
`ifdef LSU_MISALIGNED_EN
        tbl.push_back(mk(1, 2, 32'h7,        32'h11223344,  0, 0, 0,            5, 0, 4));
        tbl.push_back(mk(0, 2, 32'h7,        0,             0, 0, 32'h11223344, 3, 2, 0));
        tbl.push_back(mk(0, 1, 32'h7,        0,             0, 0, 32'h00003344, 3, 2, 0));
`else
        tbl.push_back(mk(1, 2, 32'h7,        32'h11223344,  1, 2, 0,            1, 0, 0));
        tbl.push_back(mk(0, 2, 32'h7,        0,             1, 1, 0,            1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h7,        0,             1, 1, 0,            1, 0, 0));
`endif
        tbl.push_back(mk(0, 2, 32'hFFE,      0,             1, 3, 0,            1, 0, 0));
        tbl.push_back(mk(0, 3, 32'h40,       0,             1, 0, 0,            1, 0, 0));
        tbl.push_back(mk(1, 4, 32'h40,       32'h1,         1, 0, 0,            1, 0, 0));
        tbl.push_back(mk(1, 7, 32'h40,       32'h1,         1, 0, 0,            1, 0, 0));
        tbl.push_back(mk(0, 2, 32'hFFC,      0,             0, 0, 32'h9A000000, 2, 1, 0));
        tbl.push_back(mk(0, 0, 32'hFFF,      0,             0, 0, 32'hFFFFFF9A, 2, 1, 0));
        tbl.push_back(mk(0, 1, 32'hFFF,      0,             1, 3, 0,            1, 0, 0));
        tbl.push_back(mk(0, 2, 32'hFFFFFFFC, 0,             1, 3, 0,            1, 0, 0));
        tbl.push_back(mk(0, 2, 32'hFFFFFFFE, 0,             1, 3, 0,            1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h1000,     32'h77,        1, 3, 0,            1, 0, 0));
        tbl.push_back(mk(1, 0, 32'hFFF,      32'h5A,        0, 0, 0,            2, 0, 1));
        tbl.push_back(mk(0, 4, 32'hFFF,      0,             0, 0, 32'h0000005A, 2, 1, 0));

        foreach (tbl[i]) begin
            do_txn(tbl[i], g, rb);
            compare($sformatf("dir%0d", i), g, tbl[i], rb);
            model(tbl[i], e);   // keeps the reference image in step with stores
        end

        reset_mid_store();

        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 9));
            v.we = 1'($urandom_range(0, 1));
            v.f3 = 3'($urandom_range(0, 7));
            v.wdata = $urandom;
            if (r == 0)      v.addr = 32'hFF8 + 32'($urandom_range(0, 15));
            else if (r == 1) v.addr = $urandom;
            else if (r < 5)  v.addr = 32'($urandom_range(0, 63));
            else             v.addr = 32'($urandom_range(0, 4095));
            model(v, e);
            do_txn(v, g, rb);
            compare($sformatf("rnd%0d", i), g, e, rb);
        end

        @(negedge clk);
        diffs = 0;
        for (int i = 0; i < 4096; i++) if (dmem[i] !== ref_mem[i]) diffs++;
        chk("final_mem_diffs", 32'(diffs), 32'd0);
        chk("mem_shape_violations", 32'(shape_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port: accepts one load/store request at a time from the pipeline's MEM stage and drives the byte-addressable data memory. It issues only access shapes the memory handles correctly: aligned word reads, byte stores, and aligned halfword/word stores. It performs byte-lane extraction and sign extension locally, splits misaligned accesses into multiple memory cycles, and range-checks every access. It sits between the MEM-stage control and `data_memory`.

## Interface
- `DMEM_BASE`, 32'h0000_0000, first valid byte address.
- `DMEM_SIZE`, 4096, size in bytes; power of two.
- `clk  in  1  clock`
- `reset  in  1  synchronous, active-high reset`
- `req_valid  in  1  request present`
- `req_ready  out  1  unit idle and able to accept`
- `req_we  in  1  1 = store, 0 = load`
- `req_funct3  in  3  RV32I size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)`
- `req_addr  in  32  byte address`
- `req_wdata  in  32  store data, LSB-aligned`
- `rsp_valid  out  1  one-cycle completion pulse`
- `rsp_rdata  out  32  extended load data; 0 for stores and errors`
- `rsp_err  out  1  request failed; memory was not touched`
- `rsp_cause  out  2  00 bad funct3, 01 load misaligned, 10 store misaligned, 11 access fault`
- `mem_addr  out  32  memory byte address`
- `mem_write_data  out  32  memory store data`
- `mem_read  out  1  memory read enable`
- `mem_write  out  1  memory write enable`
- `mem_funct3  out  3  memory access size`
- `mem_read_data  in  32  combinational memory read data`

## Operation
- States: IDLE, LOAD0, LOAD1, STORE, STORE_B, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch all request fields and go to the next state.
- Next-state selection from IDLE:
  - Invalid funct3 (011, 110, 111; stores with funct3[2]=1) → RESP with `rsp_err`=1, cause 00.
  - Range fault → RESP with cause 11. A range fault means `addr` < DMEM_BASE, or `addr+size-1` > DMEM_BASE+DMEM_SIZE-1, or the 32-bit addition carries out.
  - Misaligned access (offset `addr[1:0]` not a multiple of size) → see Configuration.
  - Otherwise, a load goes to LOAD0 and a store goes to STORE or STORE_B.
- Loads:
  - Always issue `mem_funct3`=010, `mem_read`=1, `mem_addr`=addr & ~3.
  - LOAD0 captures word 0. If offset+size > 4, LOAD1 captures the word at (addr & ~3)+4.
  - Bytes are selected from the concatenation {word1, word0} shifted right by 8·offset, then sign- or zero-extended per funct3.
- Stores:
  - SB, SH at offset 0, and SW at offset 0 take one STORE cycle with `mem_funct3`=funct3.
  - Every other store (SH at offset 2, misaligned SH/SW) goes through STORE_B. STORE_B issues one SB per cycle: byte k of `req_wdata` at addr+k, for k = 0..size-1, using a 2-bit byte counter.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. There is no response back-pressure.
- When not in LOAD0/LOAD1/STORE/STORE_B, all `mem_*` outputs are 0.

## Timing
- Reset values: `req_ready`=1 after the reset cycle; all other outputs 0; state IDLE.
- Request accepted at edge T. Response pulse timing:
  - Single-word load: cycle T+2.
  - Word-spanning load: cycle T+3.
  - Single-cycle store: cycle T+2.
  - STORE_B store: cycle T+1+size.
  - Error: cycle T+1.
- `req_ready`=0 from acceptance through the RESP cycle, so back-to-back requests are spaced by the response latency.
- `mem_read_data` is sampled at the end of LOAD0/LOAD1. Memory writes commit at the end of STORE/STORE_B cycles.
- Reset mid-operation: return to IDLE immediately and emit no response. Bytes of a STORE_B sequence already written stay written.
- Word-spanning accesses at the top of the range are caught by the range check before any memory cycle is issued.

## Configuration
- `LSU_MISALIGNED_EN` defined: misaligned accesses are split as described (LOAD1 / STORE_B).
- `LSU_MISALIGNED_EN` undefined:
  - Misaligned loads and stores go straight to RESP with `rsp_err`=1, cause 01 or 10.
  - LOAD1 is not built. STORE_B remains, because it is still needed for the aligned SH at offset 2.

## Structure
- Shared package `lsu_pkg` holds:
  - State encoding.
  - funct3 constants (F3_LB … F3_SW).
  - Cause codes (CAUSE_BAD_F3, CAUSE_LD_MISAL, CAUSE_ST_MISAL, CAUSE_FAULT).
- One sub-module, `lsu_load_align`: combinational extraction and extension from {word1, word0}, offset, and funct3.

## Test plan
- LW at 0x10 with memory word 0xDEADBEEF → `rsp_rdata`=0xDEADBEEF at T+2; one `mem_read` cycle at address 0x10.
- LB at 0x13 with word 0x80112233 → 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH 0xABCD at 0x22, then LHU at 0x22 → two SB cycles (0x22←CD, 0x23←AB); read returns 0x0000ABCD; bytes 0x20/0x21 unchanged.
- With the macro defined: SW 0x11223344 at 0x7, then LW at 0x7 → four SB cycles, then two reads; result 0x11223344. With the macro undefined: the SW gets `rsp_err`=1, cause 10 at T+1, and `mem_write` never asserts.
- LW at 0xFFE (DMEM_SIZE 4096) → cause 11 at T+1 with no memory cycle. A funct3=011 load → cause 00.
- Assert `reset` during the third STORE_B cycle → no `rsp_valid`, IDLE and `req_ready`=1 on the next cycle, first two bytes written.
